// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage.
// Contents: funct3 access-size codes, FSM state type, byte-strobe lookup.
package mem_pkg;

    localparam int unsigned STRB_W = 4;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned F3_W_  = 3;

    localparam logic [F3_W_-1:0] F3_B  = 3'b000;
    localparam logic [F3_W_-1:0] F3_H  = 3'b001;
    localparam logic [F3_W_-1:0] F3_W  = 3'b010;
    localparam logic [F3_W_-1:0] F3_BU = 3'b100;
    localparam logic [F3_W_-1:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Byte enables for a store of the given size (funct3[1:0]) at byte offset off.
    function automatic logic [STRB_W-1:0] wstrb_lookup(input logic [1:0] size,
                                                       input logic [1:0] off);
        logic [STRB_W-1:0] strb;
        case (size)
            2'b00:   strb = 4'b0001 << off;
            2'b01:   strb = 4'b0011 << off;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for the memory stage.
// Ports:
//   st_funct3/st_off/sdata : incoming access (misalign check + store lanes)
//   ld_funct3/ld_off/rdata : captured load access + returned bus data
//   misaligned_c           : access is misaligned or has an undefined size
//   wstrb_c/wdata_c        : store byte enables and lane-replicated data
//   ldata_c                : load data shifted to bit 0 and extended
module mem_align
    import mem_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]        st_funct3,
    input  logic [1:0]        st_off,
    input  logic [XLEN-1:0]   sdata,
    input  logic [2:0]        ld_funct3,
    input  logic [1:0]        ld_off,
    input  logic [XLEN-1:0]   rdata,
    output logic              misaligned_c,
    output logic [STRB_W-1:0] wstrb_c,
    output logic [XLEN-1:0]   wdata_c,
    output logic [XLEN-1:0]   ldata_c
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Misalign detect; undefined sizes are rejected the same way.
    always_comb begin
        misaligned_c = 1'b1;
        case (st_funct3)
            F3_B, F3_BU: misaligned_c = 1'b0;
            F3_H, F3_HU: misaligned_c = st_off[0];
            F3_W:        misaligned_c = |st_off;
            default:     misaligned_c = 1'b1;
        endcase
    end

    // Store lanes: replicate the narrow value into every lane, strobe picks one.
    always_comb begin
        wstrb_c = wstrb_lookup(st_funct3[1:0], st_off);
        case (st_funct3[1:0])
            2'b00:   wdata_c = {(XLEN/8){sdata[7:0]}};
            2'b01:   wdata_c = {(XLEN/16){sdata[15:0]}};
            default: wdata_c = sdata;
        endcase
    end

    // Load lanes: select byte/half then sign- or zero-extend.
    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_funct3)
            F3_B:    ldata_c = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            F3_BU:   ldata_c = {{(XLEN-8){1'b0}}, ld_byte};
            F3_H:    ldata_c = {{(XLEN-16){ld_half[15]}}, ld_half};
            F3_HU:   ldata_c = {{(XLEN-16){1'b0}}, ld_half};
            default: ldata_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on a ready-handshaked data port,
// drives the register-file write port and stalls upstream while waiting.
// Ports:
//   clk, rst (sync, active-low)
//   in_*      : instruction from execute (held while stall=1)
//   stall     : combinational hold request to upstream
//   dmem_*    : data-memory request/response
//   wb_*      : register-file write port
//   misalign_err, bus_err : one-cycle error pulses
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_res,
    input  logic [XLEN-1:0]   in_sdata,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_we,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [STRB_W-1:0] dmem_wstrb,
    input  logic              dmem_ready,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              wb_we,
    output logic [RD_W-1:0]   wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              misalign_err,
    output logic              bus_err
);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [RD_W-1:0]   cap_rd, cap_rd_n;
    logic [2:0]        cap_funct3, cap_funct3_n;
    logic [1:0]        cap_off, cap_off_n;
    logic              cap_load, cap_load_n;

    logic              req_n, dwe_n, wb_we_n, mis_n, bus_n, stall_c;
    logic [XLEN-1:0]   addr_n, wdata_n, wb_data_n;
    logic [STRB_W-1:0] wstrb_n;
    logic [RD_W-1:0]   wb_rd_n;

    logic              misaligned_c;
    logic [STRB_W-1:0] wstrb_c;
    logic [XLEN-1:0]   wdata_c, ldata_c;
    logic              mem_op_c;

    mem_align #(.XLEN(XLEN)) u_align (
        .st_funct3    (in_funct3),
        .st_off       (in_res[1:0]),
        .sdata        (in_sdata),
        .ld_funct3    (cap_funct3),
        .ld_off       (cap_off),
        .rdata        (dmem_rdata),
        .misaligned_c (misaligned_c),
        .wstrb_c      (wstrb_c),
        .wdata_c      (wdata_c),
        .ldata_c      (ldata_c)
    );

    assign mem_op_c = in_valid & (in_load | in_store);
    // Never ask upstream to hold while reset is asserted.
    assign stall    = stall_c & rst;

    // Next-state and next-output logic.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        cap_rd_n     = cap_rd;
        cap_funct3_n = cap_funct3;
        cap_off_n    = cap_off;
        cap_load_n   = cap_load;
        req_n        = dmem_req;
        dwe_n        = dmem_we;
        addr_n       = dmem_addr;
        wdata_n      = dmem_wdata;
        wstrb_n      = dmem_wstrb;
        wb_we_n      = 1'b0;
        wb_rd_n      = wb_rd;
        wb_data_n    = wb_data;
        mis_n        = 1'b0;
        bus_n        = 1'b0;
        stall_c      = 1'b0;

        case (state)
            IDLE: begin
                if (mem_op_c) begin
                    if (misaligned_c) begin
                        mis_n = 1'b1;
                    end else begin
                        stall_c      = 1'b1;
                        req_n        = 1'b1;
                        dwe_n        = in_store;
                        addr_n       = {in_res[XLEN-1:2], 2'b00};
                        wdata_n      = wdata_c;
                        wstrb_n      = in_store ? wstrb_c : '0;
                        cap_rd_n     = in_rd;
                        cap_funct3_n = in_funct3;
                        cap_off_n    = in_res[1:0];
                        cap_load_n   = ~in_store;
                        cnt_n        = '0;
                        state_n      = WAIT;
                    end
                end else if (in_valid) begin
                    wb_we_n   = in_we & (in_rd != '0);
                    wb_rd_n   = in_rd;
                    wb_data_n = in_res;
                end
            end
            WAIT: begin
                if (dmem_ready) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                    if (cap_load) begin
                        wb_we_n   = (cap_rd != '0);
                        wb_rd_n   = cap_rd;
                        wb_data_n = ldata_c;
                    end
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Give up: release upstream and abandon the request.
                    req_n   = 1'b0;
                    bus_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_n   = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            cap_rd       <= '0;
            cap_funct3   <= '0;
            cap_off      <= '0;
            cap_load     <= 1'b0;
            dmem_req     <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            dmem_wstrb   <= '0;
            wb_we        <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            cap_rd       <= cap_rd_n;
            cap_funct3   <= cap_funct3_n;
            cap_off      <= cap_off_n;
            cap_load     <= cap_load_n;
            dmem_req     <= req_n;
            dmem_we      <= dwe_n;
            dmem_addr    <= addr_n;
            dmem_wdata   <= wdata_n;
            dmem_wstrb   <= wstrb_n;
            wb_we        <= wb_we_n;
            wb_rd        <= wb_rd_n;
            wb_data      <= wb_data_n;
            misalign_err <= mis_n;
            bus_err      <= bus_n;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a writeback scoreboard.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_load, in_store, in_we;
    logic [2:0]  in_funct3;
    logic [31:0] in_res, in_sdata;
    logic [4:0]  in_rd;
    logic        stall, dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        wb_we, misalign_err, bus_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;
    wb_exp_t sb[$];

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
        .in_funct3(in_funct3), .in_res(in_res), .in_sdata(in_sdata),
        .in_rd(in_rd), .in_we(in_we), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_we = 1'b0;
        in_funct3 = 3'b000; in_res = '0; in_sdata = '0; in_rd = '0;
    endtask

    // Expected register value for a load of the given size at byte offset off.
    function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [31:0] sh;
        sh = rdata >> (8 * off);
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return rdata;
        endcase
    endfunction

    task automatic push_wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
        wb_exp_t e;
        e.we = we; e.rd = rd; e.data = data;
        sb.push_back(e);
    endtask

    task automatic check_wb(input string tag);
        wb_exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_we"}, 32'(wb_we), 32'(e.we));
        if (e.we) begin
            chk({tag, "_rd"}, 32'(wb_rd), 32'(e.rd));
            chk({tag, "_data"}, wb_data, e.data);
        end
    endtask

    // One aligned memory access with a given number of not-ready WAIT cycles.
    task automatic mem_access(input string tag, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input logic [4:0] rd, input int waits, input logic [31:0] rdata,
                              input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        int stalls = 0;
        in_valid = 1'b1; in_load = !st; in_store = st; in_funct3 = f3;
        in_res = addr; in_sdata = sdata; in_rd = rd; in_we = !st;
        if (st) push_wb(1'b0, rd, '0);
        else    push_wb(rd != 5'd0, rd, ld_model(f3, addr[1:0], rdata));
        #1;
        if (stall) stalls++;
        step();
        chk({tag, "_req"}, 32'(dmem_req), 32'd1);
        chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        chk({tag, "_dwe"}, 32'(dmem_we), 32'(st));
        if (st) begin
            chk({tag, "_strb"}, 32'(dmem_wstrb), 32'(exp_strb));
            chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
        end
        for (int i = 0; i < waits; i++) begin
            #1;
            if (stall) stalls++;
            step();
        end
        dmem_ready = 1'b1; dmem_rdata = rdata;
        #1;
        chk({tag, "_stall_ready"}, 32'(stall), 32'd0);
        chk({tag, "_stall_cycles"}, 32'(stalls), 32'(waits + 1));
        step();
        dmem_ready = 1'b0; dmem_rdata = '0;
        idle_in();
        chk({tag, "_req_drop"}, 32'(dmem_req), 32'd0);
        check_wb(tag);
    endtask

    initial begin
        int n;
        rst = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
        idle_in();
        step();
        step();
        // Reset state, and no stall even with a memory op presented in reset.
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_wbwe", 32'(wb_we), 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        chk("rst_errs", 32'({misalign_err, bus_err}), 32'd0);
        in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'b010; in_res = 32'h40;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        idle_in();
        rst = 1'b1;
        step();

        // ALU passthrough.
        in_valid = 1'b1; in_res = 32'h1234; in_rd = 5'd5; in_we = 1'b1;
        push_wb(1'b1, 5'd5, 32'h1234);
        #1;
        chk("alu_stall", 32'(stall), 32'd0);
        step();
        in_rd = 5'd0; in_res = 32'h55;
        push_wb(1'b0, 5'd0, '0);
        check_wb("alu");
        step();
        idle_in();
        check_wb("alu_rd0");

        // Loads with sign/zero extension, then back-to-back store.
        mem_access("lb",  1'b0, 3'b000, 32'h103, '0, 5'd7, 2, 32'h80FF_FF7F, '0, '0);
        mem_access("lbu", 1'b0, 3'b100, 32'h103, '0, 5'd8, 2, 32'h80FF_FF7F, '0, '0);
        mem_access("lh",  1'b0, 3'b001, 32'h106, '0, 5'd9, 0, 32'h8001_1234, '0, '0);
        mem_access("lhu", 1'b0, 3'b101, 32'h106, '0, 5'd9, 1, 32'h8001_1234, '0, '0);
        mem_access("lw",  1'b0, 3'b010, 32'h10C, '0, 5'd10, 3, 32'hCAFE_F00D, '0, '0);
        mem_access("sh",  1'b1, 3'b001, 32'h202, 32'hDEAD_BEEF, 5'd0, 1, '0, 4'b1100, 32'hBEEF_BEEF);
        mem_access("sb",  1'b1, 3'b000, 32'h211, 32'h0000_00A5, 5'd0, 0, '0, 4'b0010, 32'hA5A5_A5A5);
        mem_access("sw",  1'b1, 3'b010, 32'h220, 32'h1357_9BDF, 5'd0, 0, '0, 4'b1111, 32'h1357_9BDF);
        mem_access("lw_rd0", 1'b0, 3'b010, 32'h230, '0, 5'd0, 0, 32'h1111_2222, '0, '0);

        // Misaligned word load and undefined size are dropped.
        in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'b010; in_res = 32'h301; in_rd = 5'd4; in_we = 1'b1;
        push_wb(1'b0, 5'd4, '0);
        #1;
        chk("mis_stall", 32'(stall), 32'd0);
        step();
        in_funct3 = 3'b011; in_res = 32'h300;
        push_wb(1'b0, 5'd4, '0);
        chk("mis_pulse", 32'(misalign_err), 32'd1);
        chk("mis_req", 32'(dmem_req), 32'd0);
        check_wb("mis");
        step();
        idle_in();
        chk("undef_pulse", 32'(misalign_err), 32'd1);
        chk("undef_req", 32'(dmem_req), 32'd0);
        check_wb("undef");
        step();
        chk("mis_end", 32'(misalign_err), 32'd0);

        // Timeout: ready never arrives.
        in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'b010; in_res = 32'h400; in_rd = 5'd3; in_we = 1'b1;
        step();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            n++;
            if (!stall) break;
            step();
        end
        chk("to_wait_cycles", 32'(n), 32'd16);
        chk("to_req_held", 32'(dmem_req), 32'd1);
        idle_in();
        step();
        chk("to_req_drop", 32'(dmem_req), 32'd0);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_wbwe", 32'(wb_we), 32'd0);
        step();
        chk("to_bus_err_end", 32'(bus_err), 32'd0);

        // Reset in the middle of WAIT; a late ready must be ignored.
        in_valid = 1'b1; in_load = 1'b1; in_funct3 = 3'b010; in_res = 32'h500; in_rd = 5'd6; in_we = 1'b1;
        step();
        step();
        rst = 1'b0;
        idle_in();
        step();
        chk("rw_req", 32'(dmem_req), 32'd0);
        chk("rw_stall", 32'(stall), 32'd0);
        rst = 1'b1;
        dmem_ready = 1'b1; dmem_rdata = 32'h7777_7777;
        step();
        chk("rw_late_wbwe", 32'(wb_we), 32'd0);
        chk("rw_late_req", 32'(dmem_req), 32'd0);
        dmem_ready = 1'b0;

        // Back in IDLE: passthrough works without stalling.
        in_valid = 1'b1; in_res = 32'h9ABC; in_rd = 5'd12; in_we = 1'b1;
        push_wb(1'b1, 5'd12, 32'h9ABC);
        #1;
        chk("post_stall", 32'(stall), 32'd0);
        step();
        idle_in();
        check_wb("post");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
